// File: rtl/fifo_rd_packer_if.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_rd_packer_if
//  Description : FIFO read port plus packed valid/ready output stream.
//  Revision    : 1.0  initial release
// ============================================================================
interface fifo_rd_packer_if #(
    parameter int DATA_SIZE = 8,
    parameter int PACK      = 4
);
    logic                      fifo_empty;
    logic [DATA_SIZE-1:0]      fifo_rd_data;
    logic                      fifo_rd_en;
    logic                      flush;
    logic                      out_valid;
    logic                      out_ready;
    logic [DATA_SIZE*PACK-1:0] out_data;
    logic [PACK-1:0]           out_keep;
    logic                      out_last;

    modport master (
        input  fifo_empty, fifo_rd_data, flush, out_ready,
        output fifo_rd_en, out_valid, out_data, out_keep, out_last
    );

    modport slave (
        output fifo_empty, fifo_rd_data, flush, out_ready,
        input  fifo_rd_en, out_valid, out_data, out_keep, out_last
    );
endinterface
`default_nettype wire

// File: rtl/fifo_rd_packer.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_rd_packer
//  Description : Pops FIFO words and packs PACK of them per output beat;
//                flush emits a partial beat with keep mask and last flag.
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_rd_packer #(
    parameter int DATA_SIZE = 8,
    parameter int PACK      = 4
) (
    input  wire logic         rd_clk,
    input  wire logic         rd_rst,
    fifo_rd_packer_if.master  bus
);
    localparam int c_out_size = DATA_SIZE * PACK;
    localparam int c_cnt_w    = $clog2(PACK) + 1;
    localparam logic [c_cnt_w-1:0] c_last_lane = c_cnt_w'(PACK - 1);

    logic [c_out_size-1:0] r_acc;
    logic [c_cnt_w-1:0]    r_cnt;
    logic                  r_flush_pend;
    logic                  r_out_valid;
    logic [c_out_size-1:0] r_out_data;
    logic [PACK-1:0]       r_out_keep;
    logic                  r_out_last;

    logic                  w_out_free;
    logic                  w_pop;
    logic                  w_complete;
    logic                  w_flush_move;
    logic [c_out_size-1:0] w_full;
    logic [PACK-1:0]       w_keep;

    assign w_out_free   = !r_out_valid || bus.out_ready;
    // Pops stall only when the last lane would need a free output register.
    assign w_pop        = !rd_rst && !bus.fifo_empty && !bus.flush && !r_flush_pend &&
                          ((r_cnt < c_last_lane) || w_out_free);
    assign w_complete   = w_pop && (r_cnt == c_last_lane);
    assign w_flush_move = r_flush_pend && w_out_free;

    always_comb begin
        w_full = r_acc;
        w_full[(PACK-1)*DATA_SIZE +: DATA_SIZE] = bus.fifo_rd_data;
    end

    always_comb begin
        w_keep = '0;
        for (int i = 0; i < PACK; i++) begin
            w_keep[i] = (i < int'(r_cnt));
        end
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            r_acc        <= '0;
            r_cnt        <= '0;
            r_flush_pend <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_keep   <= '0;
            r_out_last   <= 1'b0;
        end else begin
            if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (w_complete) begin
                r_out_data  <= w_full;
                r_out_keep  <= '1;
                r_out_last  <= 1'b0;
                r_out_valid <= 1'b1;
                r_acc       <= '0;
                r_cnt       <= '0;
            end else if (w_pop) begin
                r_acc[int'(r_cnt)*DATA_SIZE +: DATA_SIZE] <= bus.fifo_rd_data;
                r_cnt <= r_cnt + 1'b1;
            end

            // Pops are blocked while a flush is pending, so this never races w_pop.
            if (w_flush_move) begin
                r_out_data   <= r_acc;
                r_out_keep   <= w_keep;
                r_out_last   <= 1'b1;
                r_out_valid  <= 1'b1;
                r_acc        <= '0;
                r_cnt        <= '0;
                r_flush_pend <= 1'b0;
            end else if (bus.flush && (r_cnt != '0)) begin
                r_flush_pend <= 1'b1;
            end
        end
    end

    assign bus.fifo_rd_en = w_pop;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_data   = r_out_data;
    assign bus.out_keep   = r_out_keep;
    assign bus.out_last   = r_out_last;
endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_rd_packer
//  Description : Directed self-checking bench for fifo_rd_packer (PACK=4).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fifo_rd_packer;
    localparam int c_data_size = 8;
    localparam int c_pack      = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_rd_packer_if #(.DATA_SIZE(c_data_size), .PACK(c_pack)) bus ();

    fifo_rd_packer #(.DATA_SIZE(c_data_size), .PACK(c_pack)) dut (
        .rd_clk (clk),
        .rd_rst (rst),
        .bus    (bus)
    );

    // Simple FIFO model: bench pushes at tail, DUT pops at head.
    logic [7:0] mem [0:255];
    int head = 0;
    int tail = 0;
    int pops = 0;
    int beats = 0;
    int checks = 0;
    int failures = 0;

    assign bus.fifo_empty   = (head == tail);
    assign bus.fifo_rd_data = mem[head[7:0]];

    always @(posedge clk) begin
        if (bus.fifo_rd_en) begin
            head <= head + 1;
            pops <= pops + 1;
        end
        if (!rst && bus.out_valid && bus.out_ready) beats <= beats + 1;
    end

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        mem[tail[7:0]] = d;
        tail++;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!bus.out_valid && n < 20) begin
            step();
            n++;
        end
        if (!bus.out_valid) check_val(tag, 64'd0, 64'd1);
    endtask

    initial begin
        int p0, b0;
        bus.out_ready = 1'b1;
        bus.flush     = 1'b0;
        for (int i = 1; i <= 8; i++) push(8'(i));

        // Reset with a non-empty FIFO
        step();
        step();
        check_val("rst_rd_en",  64'(bus.fifo_rd_en), 64'd0);
        check_val("rst_valid",  64'(bus.out_valid),  64'd0);
        check_val("rst_keep",   64'(bus.out_keep),   64'd0);
        check_val("rst_data",   64'(bus.out_data),   64'd0);

        // Streaming: 8 back-to-back pops
        rst = 1'b0;
        #1;
        check_val("stream_rd_en", 64'(bus.fifo_rd_en), 64'd1);
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 3) check_val("stream_pre_valid", 64'(bus.out_valid), 64'd0);
            if (k == 4) begin
                check_val("stream_b0_valid", 64'(bus.out_valid), 64'd1);
                check_val("stream_b0_data",  64'(bus.out_data),  64'h04030201);
                check_val("stream_b0_keep",  64'(bus.out_keep),  64'hF);
                check_val("stream_b0_last",  64'(bus.out_last),  64'd0);
            end
            if (k == 8) begin
                check_val("stream_b1_valid", 64'(bus.out_valid), 64'd1);
                check_val("stream_b1_data",  64'(bus.out_data),  64'h08070605);
            end
        end
        check_val("stream_pops", 64'(pops), 64'd8);
        step();
        check_val("stream_idle_valid", 64'(bus.out_valid),  64'd0);
        check_val("stream_idle_rd_en", 64'(bus.fifo_rd_en), 64'd0);

        // Backpressure
        bus.out_ready = 1'b0;
        p0 = pops;
        for (int i = 1; i <= 8; i++) push(8'(i));
        for (int k = 0; k < 10; k++) step();
        check_val("bp_pops",  64'(pops - p0),       64'd7);
        check_val("bp_rd_en", 64'(bus.fifo_rd_en),  64'd0);
        check_val("bp_valid", 64'(bus.out_valid),   64'd1);
        check_val("bp_hold",  64'(bus.out_data),    64'h04030201);
        bus.out_ready = 1'b1;
        #1;
        check_val("bp_release_rd_en", 64'(bus.fifo_rd_en), 64'd1);
        step();
        check_val("bp_b1_valid", 64'(bus.out_valid), 64'd1);
        check_val("bp_b1_data",  64'(bus.out_data),  64'h08070605);
        step();
        step();

        // Flush of a partial beat
        push(8'hA1); push(8'hA2); push(8'hA3);
        step(); step(); step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        step();
        check_val("flush_valid", 64'(bus.out_valid), 64'd1);
        check_val("flush_data",  64'(bus.out_data),  64'h00A3A2A1);
        check_val("flush_keep",  64'(bus.out_keep),  64'h7);
        check_val("flush_last",  64'(bus.out_last),  64'd1);
        step();
        b0 = beats;
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        step(); step(); step();
        check_val("flush_empty_valid", 64'(bus.out_valid), 64'd0);
        check_val("flush_empty_beats", 64'(beats),         64'(b0));

        // Flush colliding with a possible completing pop
        push(8'hB1); push(8'hB2); push(8'hB3);
        step(); step(); step();
        push(8'hB4);
        bus.flush = 1'b1;
        #1;
        check_val("coll_rd_en_flush", 64'(bus.fifo_rd_en), 64'd0);
        step();
        bus.flush = 1'b0;
        #1;
        check_val("coll_rd_en_pend", 64'(bus.fifo_rd_en), 64'd0);
        step();
        check_val("coll_valid", 64'(bus.out_valid), 64'd1);
        check_val("coll_data",  64'(bus.out_data),  64'h00B3B2B1);
        check_val("coll_keep",  64'(bus.out_keep),  64'h7);
        check_val("coll_last",  64'(bus.out_last),  64'd1);
        push(8'hB5); push(8'hB6); push(8'hB7);
        step();
        wait_valid("coll_next_timeout");
        check_val("coll_next_data", 64'(bus.out_data), 64'hB7B6B5B4);
        check_val("coll_next_last", 64'(bus.out_last), 64'd0);
        step();

        // Reset mid-operation
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) push(8'hC0 + 8'(i));
        for (int k = 0; k < 8; k++) step();
        check_val("mid_pre_valid", 64'(bus.out_valid), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        check_val("mid_rst_data",  64'(bus.out_data),  64'd0);
        bus.out_ready = 1'b1;
        push(8'hD1); push(8'hD2); push(8'hD3); push(8'hD4);
        step();
        wait_valid("mid_next_timeout");
        check_val("mid_next_data", 64'(bus.out_data), 64'hD4D3D2D1);
        check_val("mid_next_keep", 64'(bus.out_keep), 64'hF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
